decode_execute: RTL and testbench

//  RV32I decode + ID/EX pipeline register + execute stage of the 4-stage core (pc_reg/rom/if_id -> this -> regs/ram).

---
 rtl/decode_execute_pkg.sv | 42 ++++
 rtl/decode_execute_idex_pipe_reg.sv | 23 ++
 rtl/decode_execute.sv | 214 +++++++++++++++++++++
 tb/tb_decode_execute.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/decode_execute_pkg.sv
// Shared opcodes, hold codes and the ID/EX bundle layout for the RV32I
// decode/execute stage.
package decode_execute_pkg;

   localparam logic [31:0] NOP_INST  = 32'h0000_0013;
   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef enum logic [2:0] {
      HOLD_NONE = 3'd0,
      HOLD_PC   = 3'd1,
      HOLD_IF   = 3'd2,
      HOLD_ID   = 3'd3
   } hold_e;

   // Only the instruction fields execute still needs travel with the operands.
   typedef struct packed {
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [31:0] op1_jump;
      logic [31:0] op2_jump;
      logic [31:0] rs2_data;
      logic        reg_we;
      logic [4:0]  reg_waddr;
   } idex_t;

   // Decoded form of NOP_INST (addi x0,x0,0).
   localparam idex_t IDEX_NOP = '{opcode: OP_IMM, default: '0};

endpackage

// File: rtl/decode_execute_idex_pipe_reg.sv
// ID/EX pipeline register: async active-low clear and synchronous flush both
// load the NOP bundle.
module idex_pipe_reg
   import decode_execute_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  flush,
   input  idex_t d,
   output idex_t q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= IDEX_NOP;
      end else if (flush) begin
         q <= IDEX_NOP;
      end else begin
         q <= d;
      end
   end

endmodule

// File: rtl/decode_execute.sv
// RV32I decode, ID/EX register and execute: writeback, data-RAM access and
// branch/jump redirect with a one-slot flush of the following instruction.
module decode_execute
   import decode_execute_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] inst_i,
   input  logic [31:0] inst_addr_i,
   input  logic [31:0] reg1_rdata_i,
   input  logic [31:0] reg2_rdata_i,
   input  logic [31:0] mem_rdata_i,
   output logic [4:0]  reg1_raddr_o,
   output logic [4:0]  reg2_raddr_o,
   output logic        reg_we_o,
   output logic [4:0]  reg_waddr_o,
   output logic [31:0] reg_wdata_o,
   output logic        mem_we_o,
   output logic [31:0] mem_raddr_o,
   output logic [31:0] mem_waddr_o,
   output logic [31:0] mem_wdata_o,
   output logic        jump_flag_o,
   output logic [31:0] jump_addr_o,
   output logic [2:0]  hold_flag_o
);

   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] rs1_data, rs2_data;
   idex_t       dec, ex;
   logic        flush;

   assign opcode       = inst_i[6:0];
   assign rd           = inst_i[11:7];
   assign reg1_raddr_o = inst_i[19:15];
   assign reg2_raddr_o = inst_i[24:20];

   assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
   assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
   assign imm_b = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
   assign imm_u = {inst_i[31:12], 12'b0};
   assign imm_j = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

   // Bypass the result currently leaving execute; x0 is never forwarded.
   assign rs1_data = (reg_we_o && reg_waddr_o != 5'd0 && reg_waddr_o == reg1_raddr_o)
                     ? reg_wdata_o : reg1_rdata_i;
   assign rs2_data = (reg_we_o && reg_waddr_o != 5'd0 && reg_waddr_o == reg2_raddr_o)
                     ? reg_wdata_o : reg2_rdata_i;

   always_comb begin
      dec           = '0;
      dec.opcode    = opcode;
      dec.funct3    = inst_i[14:12];
      dec.funct7    = inst_i[31:25];
      dec.rs2_data  = rs2_data;
      dec.reg_waddr = rd;
      case (opcode)
         OP_LUI:    begin dec.op1 = imm_u;       dec.op2 = ZERO_WORD; dec.reg_we = 1'b1; end
         OP_AUIPC:  begin dec.op1 = inst_addr_i; dec.op2 = imm_u;     dec.reg_we = 1'b1; end
         OP_JAL: begin
            dec.op1      = inst_addr_i;
            dec.op2      = 32'd4;
            dec.op1_jump = inst_addr_i;
            dec.op2_jump = imm_j;
            dec.reg_we   = 1'b1;
         end
         OP_JALR: begin
            dec.op1      = inst_addr_i;
            dec.op2      = 32'd4;
            dec.op1_jump = rs1_data;
            dec.op2_jump = imm_i;
            dec.reg_we   = 1'b1;
         end
         OP_BRANCH: begin
            dec.op1      = rs1_data;
            dec.op2      = rs2_data;
            dec.op1_jump = inst_addr_i;
            dec.op2_jump = imm_b;
         end
         OP_LOAD:   begin dec.op1 = rs1_data; dec.op2 = imm_i;    dec.reg_we = 1'b1; end
         OP_STORE:  begin dec.op1 = rs1_data; dec.op2 = imm_s;                        end
         OP_IMM:    begin dec.op1 = rs1_data; dec.op2 = imm_i;    dec.reg_we = 1'b1; end
         OP_REG:    begin dec.op1 = rs1_data; dec.op2 = rs2_data; dec.reg_we = 1'b1; end
         default: ;
      endcase
   end

   assign flush = (hold_flag_o >= HOLD_ID);

   idex_pipe_reg u_idex (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .d     (dec),
      .q     (ex)
   );

   logic [31:0] sum, result, jump_target;
   logic        wr_en, jump, alt, legal, is_reg;

   assign sum = ex.op1 + ex.op2;
   assign alt = (ex.funct7 == 7'h20);

   always_comb begin
      reg_we_o    = 1'b0;
      reg_waddr_o = 5'd0;
      reg_wdata_o = ZERO_WORD;
      mem_we_o    = 1'b0;
      mem_raddr_o = ZERO_WORD;
      mem_waddr_o = ZERO_WORD;
      mem_wdata_o = ZERO_WORD;
      jump_flag_o = 1'b0;
      jump_addr_o = ZERO_WORD;
      hold_flag_o = HOLD_NONE;
      wr_en       = 1'b0;
      jump        = 1'b0;
      result      = ZERO_WORD;
      jump_target = ex.op1_jump + ex.op2_jump;
      is_reg      = (ex.opcode == OP_REG);
      legal       = 1'b0;

      case (ex.opcode)
         OP_LUI, OP_AUIPC: begin
            wr_en  = 1'b1;
            result = sum;
         end
         OP_JAL: begin
            wr_en  = 1'b1;
            result = sum;
            jump   = 1'b1;
         end
         OP_JALR: begin
            wr_en       = 1'b1;
            result      = sum;
            jump        = 1'b1;
            jump_target = jump_target & ~32'd1;
         end
         OP_IMM, OP_REG: begin
            // Immediate forms carry imm bits in funct7 except for the shifts.
            if (is_reg) begin
               legal = (ex.funct7 == 7'h00) ||
                       (alt && (ex.funct3 == 3'b000 || ex.funct3 == 3'b101));
            end else begin
               legal = (ex.funct3 == 3'b001) ? (ex.funct7 == 7'h00) :
                       (ex.funct3 == 3'b101) ? (ex.funct7 == 7'h00 || alt) : 1'b1;
            end
            wr_en = legal;
            case (ex.funct3)
               3'b000:  result = (is_reg && alt) ? ex.op1 - ex.op2 : sum;
               3'b001:  result = ex.op1 << ex.op2[4:0];
               3'b010:  result = {31'b0, $signed(ex.op1) < $signed(ex.op2)};
               3'b011:  result = {31'b0, ex.op1 < ex.op2};
               3'b100:  result = ex.op1 ^ ex.op2;
               3'b101:  result = alt ? 32'($signed(ex.op1) >>> ex.op2[4:0])
                                     : ex.op1 >> ex.op2[4:0];
               3'b110:  result = ex.op1 | ex.op2;
               default: result = ex.op1 & ex.op2;
            endcase
         end
         OP_LOAD: begin
            mem_raddr_o = sum;
            wr_en       = 1'b1;
            case (ex.funct3)
               3'b000:  result = {{24{mem_rdata_i[{sum[1:0], 3'b111}]}},
                                  mem_rdata_i[{sum[1:0], 3'b000} +: 8]};
               3'b001:  result = {{16{mem_rdata_i[{sum[1], 4'b1111}]}},
                                  mem_rdata_i[{sum[1], 4'b0000} +: 16]};
               3'b010:  result = mem_rdata_i;
               3'b100:  result = {24'b0, mem_rdata_i[{sum[1:0], 3'b000} +: 8]};
               3'b101:  result = {16'b0, mem_rdata_i[{sum[1], 4'b0000} +: 16]};
               default: wr_en  = 1'b0;
            endcase
         end
         OP_STORE: begin
            if (ex.funct3 == 3'b000 || ex.funct3 == 3'b001 || ex.funct3 == 3'b010) begin
               mem_we_o    = 1'b1;
               mem_raddr_o = sum;
               mem_waddr_o = sum;
               mem_wdata_o = mem_rdata_i;
               case (ex.funct3)
                  3'b000:  mem_wdata_o[{sum[1:0], 3'b000} +: 8] = ex.rs2_data[7:0];
                  3'b001:  mem_wdata_o[{sum[1], 4'b0000} +: 16] = ex.rs2_data[15:0];
                  default: mem_wdata_o = ex.rs2_data;
               endcase
            end
         end
         OP_BRANCH: begin
            case (ex.funct3)
               3'b000:  jump = (ex.op1 == ex.op2);
               3'b001:  jump = (ex.op1 != ex.op2);
               3'b100:  jump = ($signed(ex.op1) <  $signed(ex.op2));
               3'b101:  jump = ($signed(ex.op1) >= $signed(ex.op2));
               3'b110:  jump = (ex.op1 <  ex.op2);
               3'b111:  jump = (ex.op1 >= ex.op2);
               default: jump = 1'b0;
            endcase
         end
         default: ;
      endcase

      if (wr_en && ex.reg_we && ex.reg_waddr != 5'd0) begin
         reg_we_o    = 1'b1;
         reg_waddr_o = ex.reg_waddr;
         reg_wdata_o = result;
      end
      if (jump) begin
         jump_flag_o = 1'b1;
         jump_addr_o = jump_target;
         hold_flag_o = HOLD_ID;
      end
   end

endmodule

// File: tb/tb_decode_execute.sv
// Directed-vector bench: each issued instruction queues its expected execute
// outputs; a negedge monitor pops and compares one cycle later.
module tb_decode_execute;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] inst_i, inst_addr_i, reg1_rdata_i, reg2_rdata_i, mem_rdata_i;
   logic [4:0]  reg1_raddr_o, reg2_raddr_o, reg_waddr_o;
   logic        reg_we_o, mem_we_o, jump_flag_o;
   logic [31:0] reg_wdata_o, mem_raddr_o, mem_waddr_o, mem_wdata_o, jump_addr_o;
   logic [2:0]  hold_flag_o;

   decode_execute dut (
      .clk          (clk),
      .rst          (rst),
      .inst_i       (inst_i),
      .inst_addr_i  (inst_addr_i),
      .reg1_rdata_i (reg1_rdata_i),
      .reg2_rdata_i (reg2_rdata_i),
      .mem_rdata_i  (mem_rdata_i),
      .reg1_raddr_o (reg1_raddr_o),
      .reg2_raddr_o (reg2_raddr_o),
      .reg_we_o     (reg_we_o),
      .reg_waddr_o  (reg_waddr_o),
      .reg_wdata_o  (reg_wdata_o),
      .mem_we_o     (mem_we_o),
      .mem_raddr_o  (mem_raddr_o),
      .mem_waddr_o  (mem_waddr_o),
      .mem_wdata_o  (mem_wdata_o),
      .jump_flag_o  (jump_flag_o),
      .jump_addr_o  (jump_addr_o),
      .hold_flag_o  (hold_flag_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned cyc;
      string       name;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        mwe;
      logic [31:0] maddr;
      logic [31:0] mwd;
      logic        jf;
      logic [31:0] ja;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned cyc = 0;
   int          n_vec = 0;
   int          n_bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input string fld, input logic [31:0] act,
                      input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
         exp_t e;
         e = sb_q.pop_front();
         chk(e.name, "reg_we",    {31'b0, reg_we_o},    {31'b0, e.we});
         chk(e.name, "reg_waddr", {27'b0, reg_waddr_o}, {27'b0, e.wa});
         chk(e.name, "reg_wdata", reg_wdata_o,          e.wd);
         chk(e.name, "mem_we",    {31'b0, mem_we_o},    {31'b0, e.mwe});
         chk(e.name, "mem_raddr", mem_raddr_o,          e.maddr);
         chk(e.name, "mem_waddr", mem_waddr_o,          e.mwe ? e.maddr : 32'h0);
         chk(e.name, "mem_wdata", mem_wdata_o,          e.mwd);
         chk(e.name, "jump_flag", {31'b0, jump_flag_o}, {31'b0, e.jf});
         chk(e.name, "jump_addr", jump_addr_o,          e.ja);
         chk(e.name, "hold_flag", {29'b0, hold_flag_o}, e.jf ? 32'd3 : 32'd0);
         $display("vector %-10s we=%0d rd=%0d wdata=%h mem_we=%0d maddr=%h mwdata=%h jump=%0d target=%h hold=%0d",
                  e.name, reg_we_o, reg_waddr_o, reg_wdata_o, mem_we_o, mem_raddr_o,
                  mem_wdata_o, jump_flag_o, jump_addr_o, hold_flag_o);
      end
   end

   task automatic issue(input string nm, input logic [31:0] inst, input logic [31:0] pc,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic mwe, input logic [31:0] maddr, input logic [31:0] mwd,
                        input logic jf, input logic [31:0] ja);
      exp_t e;
      @(posedge clk);
      #1;
      inst_i       = inst;
      inst_addr_i  = pc;
      reg1_rdata_i = r1;
      reg2_rdata_i = r2;
      e = '{cyc: cyc, name: nm, we: we, wa: wa, wd: wd, mwe: mwe, maddr: maddr,
            mwd: mwd, jf: jf, ja: ja};
      sb_q.push_back(e);
   endtask

   task automatic issue_idle(input string nm, input logic [31:0] inst, input logic [31:0] pc,
                             input logic [31:0] r1, input logic [31:0] r2);
      issue(nm, inst, pc, r1, r2, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
   endtask

   initial begin
      rst          = 1'b0;
      inst_i       = 32'h0;
      inst_addr_i  = 32'h0;
      reg1_rdata_i = 32'h0;
      reg2_rdata_i = 32'h0;
      mem_rdata_i  = 32'hAABB_CCDD;
      repeat (2) @(posedge clk);
      #1;
      chk("reset", "reg_we",    {31'b0, reg_we_o},    32'h0);
      chk("reset", "reg_wdata", reg_wdata_o,          32'h0);
      chk("reset", "mem_we",    {31'b0, mem_we_o},    32'h0);
      chk("reset", "mem_raddr", mem_raddr_o,          32'h0);
      chk("reset", "jump_flag", {31'b0, jump_flag_o}, 32'h0);
      chk("reset", "hold_flag", {29'b0, hold_flag_o}, 32'h0);
      chk("reset", "rs1_addr",  {27'b0, reg1_raddr_o}, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      issue_idle("nop",     32'h0000_0013, 32'h00, 32'h0, 32'h0);
      issue("addi_x1",      32'h0050_0093, 32'h04, 32'h0, 32'h0, 1, 5'd1, 32'd5,        0, 0, 0, 0, 0);
      issue("addi_fwd",     32'h0030_8113, 32'h08, 32'h0, 32'h0, 1, 5'd2, 32'd8,        0, 0, 0, 0, 0);
      chk("addi_fwd", "rs1_addr", {27'b0, reg1_raddr_o}, 32'd1);
      chk("addi_fwd", "rs2_addr", {27'b0, reg2_raddr_o}, 32'd3);
      issue("sub_fwd",      32'h4020_81B3, 32'h0C, 32'd5, 32'h0, 1, 5'd3, 32'hFFFF_FFFD, 0, 0, 0, 0, 0);
      issue("sra",          32'h4020_D233, 32'h10, 32'h8000_0000, 32'd4, 1, 5'd4, 32'hF800_0000, 0, 0, 0, 0, 0);
      issue("sltiu",        32'hFFF0_B293, 32'h14, 32'd3, 32'h0, 1, 5'd5, 32'd1,        0, 0, 0, 0, 0);
      issue_idle("addi_x0", 32'h0050_0013, 32'h18, 32'h0, 32'h0);
      issue_idle("bne_nt",  32'h0020_9463, 32'h0C, 32'd7, 32'd7);
      issue("beq_t",        32'h0000_0463, 32'h10, 32'h0, 32'h0, 0, 5'd0, 32'h0,        0, 0, 0, 1, 32'h18);
      issue_idle("flushed1", 32'h0010_0293, 32'h14, 32'h0, 32'h0);
      issue("jal",          32'h0100_00EF, 32'h20, 32'h0, 32'h0, 1, 5'd1, 32'h24,       0, 0, 0, 1, 32'h30);
      issue_idle("flushed2", 32'h0010_0313, 32'h24, 32'h0, 32'h0);
      issue("sw",           32'h0010_2223, 32'h30, 32'h0, 32'hAABB_CCDD, 0, 5'd0, 32'h0, 1, 32'd4, 32'hAABB_CCDD, 0, 0);
      issue("lw",           32'h0040_2183, 32'h34, 32'h0, 32'h0, 1, 5'd3, 32'hAABB_CCDD, 0, 32'd4, 0, 0, 0);
      issue("lb_a7",        32'h0070_0203, 32'h38, 32'h0, 32'h0, 1, 5'd4, 32'hFFFF_FFAA, 0, 32'd7, 0, 0, 0);
      issue("sb_a5",        32'h0020_02A3, 32'h3C, 32'h0, 32'h11, 0, 5'd0, 32'h0, 1, 32'd5, 32'hAABB_11DD, 0, 0);
      issue("lhu_a6",       32'h0060_5383, 32'h40, 32'h0, 32'h0, 1, 5'd7, 32'h0000_AABB, 0, 32'd6, 0, 0, 0);
      issue("jalr",         32'h0082_80E7, 32'h40, 32'h101, 32'h0, 1, 5'd1, 32'h44,    0, 0, 0, 1, 32'h108);
      issue_idle("flushed3", 32'h0010_0293, 32'h44, 32'h0, 32'h0);

      // Reset lands while this addi sits in the ID/EX register.
      issue_idle("rst_mid", 32'h0050_0093, 32'h48, 32'h0, 32'h0);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      inst_i = 32'h0000_0013;
      repeat (2) @(posedge clk);
      #1;
      chk("in_reset", "reg_we", {31'b0, reg_we_o}, 32'h0);
      rst = 1'b1;
      issue_idle("post_nop", 32'h0000_0013, 32'h00, 32'h0, 32'h0);
      issue("post_addi",    32'h0050_0093, 32'h04, 32'h0, 32'h0, 1, 5'd1, 32'd5,        0, 0, 0, 0, 0);
      issue_idle("tail_nop", 32'h0000_0013, 32'h08, 32'h0, 32'h0);

      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
      @(posedge clk);
      if (sb_q.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain_timeout pending=%0d required=0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
